// File: rtl/inst_fetch_buffer.sv
// ---------------------------------------------------------------------------
// inst_fetch_buffer
//
// Instruction fetch stage in front of the CPU controller. Each rising edge
// of the fetch permit requests one Avalon-MM burst of BURST_LENGTH words at
// the current fetch PC. The returned words go into a circular instruction
// FIFO whose head is presented to the controller. A jump flushes the FIFO
// and redirects both the fetch PC and the head PC.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_permit_fetch           fetch permit level (a rising edge requests a burst)
//   o_fetch_complete         one-cycle pulse, burst fully written to the FIFO
//   o_inst / o_inst_valid    FIFO head word and head-valid flag
//   o_empty                  FIFO empty
//   o_inst_pc                byte address of the head word
//   i_inst_complete          pop the head (ignored when empty)
//   i_jump / i_jump_addr     flush and redirect strobe, target byte address
//   o_avm_*                  Avalon-MM read master (address, read, burstcount)
//   i_avm_*                  Avalon-MM slave response (waitrequest, data, valid)
// ---------------------------------------------------------------------------
module inst_fetch_buffer #(
    parameter int unsigned           WORD_BITS    = 32,
    parameter int unsigned           ADDR_BITS    = 32,
    parameter int unsigned           BURST_LENGTH = 4,
    parameter int unsigned           DEPTH        = 8,
    parameter logic [ADDR_BITS-1:0]  RESET_PC     = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_permit_fetch,
    output logic                  o_fetch_complete,
    output logic [WORD_BITS-1:0]  o_inst,
    output logic                  o_inst_valid,
    output logic                  o_empty,
    output logic [ADDR_BITS-1:0]  o_inst_pc,
    input  logic                  i_inst_complete,
    input  logic                  i_jump,
    input  logic [ADDR_BITS-1:0]  i_jump_addr,
    output logic [ADDR_BITS-1:0]  o_avm_address,
    output logic                  o_avm_read,
    output logic [3:0]            o_avm_burstcount,
    input  logic                  i_avm_waitrequest,
    input  logic [WORD_BITS-1:0]  i_avm_readdata,
    input  logic                  i_avm_readdatavalid
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BCNT_W = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic                   req_q, req_d;
    logic                   permit_prev_q;
    logic                   stale_q, stale_d;
    logic [BCNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [ADDR_BITS-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_BITS-1:0]   avm_addr_q, avm_addr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ADDR_BITS-1:0]   inst_pc_q, inst_pc_d;
    logic [WORD_BITS-1:0]   mem [DEPTH];

    logic                   permit_edge;
    logic                   stale_now;
    logic                   push;
    logic                   pop;
    logic [CNT_W-1:0]       used;
    logic                   free_ok;
    logic                   last_beat;

    // A jump in the same cycle as a beat already makes that beat stale, so
    // the current-cycle view combines the registered flag with the strobe.
    assign stale_now   = stale_q | i_jump;
    assign permit_edge = i_permit_fetch & ~permit_prev_q;
    assign push        = (state_q == S_RECV) && i_avm_readdatavalid && !stale_now;
    assign pop         = i_inst_complete && (count_q != '0);
    assign used        = count_q + CNT_W'(push);
    assign free_ok     = (CNT_W'(DEPTH) - used) >= CNT_W'(BURST_LENGTH);
    assign last_beat   = (beat_cnt_q == BCNT_W'(BURST_LENGTH - 1));

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path
        // through the case statement can leave it unassigned (no latches).
        state_d    = state_q;
        req_d      = req_q;
        stale_d    = stale_q;
        beat_cnt_d = beat_cnt_q;
        fetch_pc_d = fetch_pc_q;
        avm_addr_d = avm_addr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inst_pc_d  = inst_pc_q;

        if (permit_edge) begin
            req_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // Starting is deferred during a jump cycle so the pending
                // request is served from the redirected PC one cycle later.
                if (req_q && free_ok && !i_jump) begin
                    state_d    = S_REQ;
                    req_d      = 1'b0;
                    avm_addr_d = fetch_pc_q;
                end
            end
            S_REQ: begin
                if (i_jump) begin
                    stale_d = 1'b1;
                end
                if (!i_avm_waitrequest) begin
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (i_jump) begin
                    stale_d = 1'b1;
                end
                if (i_avm_readdatavalid) begin
                    beat_cnt_d = beat_cnt_q + BCNT_W'(1);
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        stale_d    = 1'b0;
                        if (stale_now) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d    = S_DONE;
                            fetch_pc_d = fetch_pc_q + ADDR_BITS'(4 * BURST_LENGTH);
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Jump overrides any same-cycle push, pop or PC advance.
        if (i_jump) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            inst_pc_d  = i_jump_addr;
            fetch_pc_d = i_jump_addr;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                inst_pc_d = inst_pc_q + ADDR_BITS'(4);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            req_q         <= 1'b0;
            permit_prev_q <= 1'b0;
            stale_q       <= 1'b0;
            beat_cnt_q    <= '0;
            fetch_pc_q    <= RESET_PC;
            avm_addr_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            inst_pc_q     <= RESET_PC;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            permit_prev_q <= i_permit_fetch;
            stale_q       <= stale_d;
            beat_cnt_q    <= beat_cnt_d;
            fetch_pc_q    <= fetch_pc_d;
            avm_addr_q    <= avm_addr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            inst_pc_q     <= inst_pc_d;
        end
    end

    // NOTE: the FIFO storage has no reset; entries are only ever read while
    // count_q says they were written, and the head output is masked when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_avm_readdata;
        end
    end

    assign o_fetch_complete = (state_q == S_DONE);
    assign o_avm_read       = (state_q == S_REQ);
    assign o_avm_address    = o_avm_read ? avm_addr_q : '0;
    assign o_avm_burstcount = o_avm_read ? 4'(BURST_LENGTH) : 4'd0;
    assign o_empty          = (count_q == '0);
    assign o_inst_valid     = !o_empty;
    assign o_inst           = o_empty ? '0 : mem[rd_ptr_q];
    assign o_inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_buffer
//
// Directed bench for inst_fetch_buffer. A small Avalon slave (configurable
// stall and beat spacing) answers bursts with word(addr) = (addr/4+1)*0x11.
// A queue-based model of the instruction stream (head PC, fetch PC, stale
// bursts, completion pulses) is compared against the DUT every cycle, and
// literal expectations pin the model at key points.
// ---------------------------------------------------------------------------
module tb_inst_fetch_buffer;

    localparam int BL    = 4;
    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        i_permit_fetch;
    logic        o_fetch_complete;
    logic [31:0] o_inst;
    logic        o_inst_valid;
    logic        o_empty;
    logic [31:0] o_inst_pc;
    logic        i_inst_complete;
    logic        i_jump;
    logic [31:0] i_jump_addr;
    logic [31:0] o_avm_address;
    logic        o_avm_read;
    logic [3:0]  o_avm_burstcount;
    logic        i_avm_waitrequest;
    logic [31:0] i_avm_readdata;
    logic        i_avm_readdatavalid;

    inst_fetch_buffer #(
        .WORD_BITS    (32),
        .ADDR_BITS    (32),
        .BURST_LENGTH (BL),
        .DEPTH        (DEPTH),
        .RESET_PC     (32'h0)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_permit_fetch      (i_permit_fetch),
        .o_fetch_complete    (o_fetch_complete),
        .o_inst              (o_inst),
        .o_inst_valid        (o_inst_valid),
        .o_empty             (o_empty),
        .o_inst_pc           (o_inst_pc),
        .i_inst_complete     (i_inst_complete),
        .i_jump              (i_jump),
        .i_jump_addr         (i_jump_addr),
        .o_avm_address       (o_avm_address),
        .o_avm_read          (o_avm_read),
        .o_avm_burstcount    (o_avm_burstcount),
        .i_avm_waitrequest   (i_avm_waitrequest),
        .i_avm_readdata      (i_avm_readdata),
        .i_avm_readdatavalid (i_avm_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the instruction stream.
    logic [31:0] q[$];
    logic [31:0] head_pc;
    logic [31:0] fetch_pc_m;
    logic        stale_m;
    logic        exp_complete;
    logic        req_seen;
    logic [31:0] req_addr_exp;
    logic        chk_en;
    int          n_complete;

    // Slave state.
    int          stall_cfg;
    int          gap_cfg;
    int          s_beats_left;
    int          s_idx;
    int          s_gap_cnt;
    int          s_stall_cnt;
    logic [31:0] s_base;
    int          n_bursts;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return ((a >> 2) + 32'd1) * 32'h11;
    endfunction

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("empty",      64'(o_empty),      64'(q.size() == 0));
            check("inst_valid", 64'(o_inst_valid), 64'(q.size() != 0));
            check("inst",       64'(o_inst),       64'((q.size() != 0) ? q[0] : 32'h0));
            check("inst_pc",    64'(o_inst_pc),    64'(head_pc));
            check("complete",   64'(o_fetch_complete), 64'(exp_complete));
            if (o_avm_read) begin
                check("avm_address",    64'(o_avm_address),    64'(req_addr_exp));
                check("avm_burstcount", 64'(o_avm_burstcount), 64'(BL));
            end else begin
                check("avm_address_idle",    64'(o_avm_address),    64'h0);
                check("avm_burstcount_idle", 64'(o_avm_burstcount), 64'h0);
            end
        end
    end

    // One clock cycle: drive the slave response, take the edge, update the model.
    task automatic step();
        logic        rdv;
        logic [31:0] rdata;
        logic        wr;
        logic        inflight;
        logic        last;
        rdv = 1'b0; rdata = '0; wr = 1'b0; last = 1'b0;
        inflight = o_avm_read || (s_beats_left != 0);
        if (s_beats_left != 0) begin
            if (s_gap_cnt == 0) begin
                rdv   = 1'b1;
                rdata = word_at(s_base + 32'(4 * s_idx));
                s_idx++;
                s_beats_left--;
                s_gap_cnt = gap_cfg;
                last = (s_beats_left == 0);
            end else begin
                s_gap_cnt--;
            end
        end else if (o_avm_read) begin
            if (s_stall_cnt < stall_cfg) begin
                wr = 1'b1;
                s_stall_cnt++;
            end else begin
                s_base       = o_avm_address;
                s_beats_left = BL;
                s_idx        = 0;
                s_gap_cnt    = 0;
                s_stall_cnt  = 0;
                n_bursts++;
                req_seen     = 1'b0;
            end
        end
        i_avm_waitrequest   = wr;
        i_avm_readdatavalid = rdv;
        i_avm_readdata      = rdata;

        @(posedge clk);
        exp_complete = 1'b0;
        if (i_jump) begin
            q.delete();
            head_pc    = i_jump_addr;
            fetch_pc_m = i_jump_addr;
            if (inflight) stale_m = 1'b1;
        end else begin
            if (i_inst_complete && q.size() != 0) begin
                void'(q.pop_front());
                head_pc = head_pc + 32'd4;
            end
            if (rdv && !stale_m) begin
                check("push_not_full", 64'(q.size() < DEPTH), 64'h1);
                q.push_back(rdata);
            end
        end
        if (last) begin
            if (!stale_m && !i_jump) begin
                fetch_pc_m   = fetch_pc_m + 32'(4 * BL);
                exp_complete = 1'b1;
            end
            stale_m = 1'b0;
        end

        #1;
        if (o_fetch_complete) n_complete++;
        if (o_avm_read && !req_seen) begin
            req_seen     = 1'b1;
            req_addr_exp = fetch_pc_m;
            check("request_free_space", 64'(q.size() <= DEPTH - BL), 64'h1);
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic permit_pulse();
        i_permit_fetch = 1'b1;
        step();
        step();
        i_permit_fetch = 1'b0;
    endtask

    task automatic do_jump(input logic [31:0] addr);
        i_jump      = 1'b1;
        i_jump_addr = addr;
        step();
        i_jump      = 1'b0;
        i_jump_addr = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nb;
        int nc;
        logic found;

        rst = 1'b1;
        i_permit_fetch = 0; i_inst_complete = 0; i_jump = 0; i_jump_addr = '0;
        i_avm_waitrequest = 0; i_avm_readdata = '0; i_avm_readdatavalid = 0;
        chk_en = 1'b0;
        stall_cfg = 0; gap_cfg = 0;
        s_beats_left = 0; s_idx = 0; s_gap_cnt = 0; s_stall_cnt = 0; s_base = '0;
        n_bursts = 0; n_complete = 0;
        q.delete();
        head_pc = 32'h0; fetch_pc_m = 32'h0; stale_m = 0; exp_complete = 0;
        req_seen = 0; req_addr_exp = '0;

        repeat (3) @(negedge clk);
        check("rst_complete",   64'(o_fetch_complete), 64'h0);
        check("rst_inst_valid", 64'(o_inst_valid),     64'h0);
        check("rst_empty",      64'(o_empty),          64'h1);
        check("rst_inst",       64'(o_inst),           64'h0);
        check("rst_inst_pc",    64'(o_inst_pc),        64'h0);
        check("rst_read",       64'(o_avm_read),       64'h0);
        check("rst_address",    64'(o_avm_address),    64'h0);
        check("rst_burstcount", 64'(o_avm_burstcount), 64'h0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Basic burst: permit held 4 cycles, read rises two cycles after the edge.
        i_permit_fetch = 1'b1;
        step();
        check("latency_n1_read", 64'(o_avm_read), 64'h0);
        step();
        check("latency_n2_read", 64'(o_avm_read), 64'h1);
        check("basic_address",   64'(o_avm_address), 64'h0);
        step();
        step();
        i_permit_fetch = 1'b0;
        run(10);
        check("basic_bursts",   64'(n_bursts),   64'd1);
        check("basic_complete", 64'(n_complete), 64'd1);
        check("basic_inst",     64'(o_inst),     64'h11);
        check("basic_inst_pc",  64'(o_inst_pc),  64'h0);

        // Four pops: head PC steps 0,4,8,C.
        i_inst_complete = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("pop_pc", 64'(o_inst_pc), 64'(4 * k));
            step();
        end
        i_inst_complete = 1'b0;
        check("pop_empty",    64'(o_empty),   64'h1);
        check("pop_pc_final", 64'(o_inst_pc), 64'h10);

        // Next burst reads 0x10 while pop is held: push and pop in the same cycles.
        permit_pulse();
        i_inst_complete = 1'b1;
        run(10);
        i_inst_complete = 1'b0;
        check("pushpop_base",     64'(s_base),     64'h10);
        check("pushpop_empty",    64'(o_empty),    64'h1);
        check("pushpop_pc",       64'(o_inst_pc),  64'h20);
        check("pushpop_complete", 64'(n_complete), 64'd2);

        // Slave stall of 3 cycles and beats two cycles apart.
        stall_cfg = 3; gap_cfg = 1;
        permit_pulse();
        run(20);
        stall_cfg = 0; gap_cfg = 0;
        check("stall_base",     64'(s_base),     64'h20);
        check("stall_complete", 64'(n_complete), 64'd3);
        check("stall_head",     64'(o_inst),     64'h99);

        // Fill the FIFO to 8 entries, then jump to 0x200.
        permit_pulse();
        run(10);
        check("full_base",  64'(s_base),  64'h30);
        check("full_valid", 64'(o_inst_valid), 64'h1);
        do_jump(32'h200);
        check("jump_full_empty", 64'(o_empty),   64'h1);
        check("jump_full_pc",    64'(o_inst_pc), 64'h200);
        permit_pulse();
        run(10);
        check("jump_full_next_base", 64'(s_base), 64'h200);
        check("jump_full_next_inst", 64'(o_inst), 64'h891);

        // Jump to 0x80 in the middle of a burst at 0x40.
        do_jump(32'h40);
        permit_pulse();
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (s_beats_left == 2 && s_idx == 2) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("midburst_two_beats_seen", 64'(found), 64'h1);
        nc = n_complete;
        do_jump(32'h80);
        run(10);
        check("midburst_no_complete", 64'(n_complete), 64'(nc));
        check("midburst_empty",       64'(o_empty),    64'h1);
        check("midburst_pc",          64'(o_inst_pc),  64'h80);
        permit_pulse();
        run(10);
        check("midburst_next_base", 64'(s_base), 64'h80);

        // Free-space gating: 6 of 8 entries held, request waits for two pops.
        permit_pulse();
        run(10);
        check("gate_fill_base", 64'(s_base), 64'h90);
        i_inst_complete = 1'b1;
        step();
        step();
        i_inst_complete = 1'b0;
        check("gate_pc_after_two_pops", 64'(o_inst_pc), 64'h88);
        nb = n_bursts;
        permit_pulse();
        run(4);
        check("gate_blocked_read",   64'(o_avm_read), 64'h0);
        check("gate_blocked_bursts", 64'(n_bursts),   64'(nb));
        i_inst_complete = 1'b1;
        step();
        i_inst_complete = 1'b0;
        run(3);
        check("gate_still_blocked", 64'(n_bursts), 64'(nb));
        i_inst_complete = 1'b1;
        step();
        i_inst_complete = 1'b0;
        run(10);
        check("gate_released_bursts", 64'(n_bursts), 64'(nb + 1));
        check("gate_released_base",   64'(s_base),   64'hA0);

        // Fetch PC wrap from 0xFFFFFFF0 to 0.
        do_jump(32'hFFFF_FFF0);
        permit_pulse();
        run(10);
        check("wrap_base_hi", 64'(s_base),    64'hFFFF_FFF0);
        check("wrap_head_pc", 64'(o_inst_pc), 64'hFFFF_FFF0);
        permit_pulse();
        run(10);
        check("wrap_base_zero", 64'(s_base), 64'h0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_buffer.md
# inst_fetch_buffer

Instruction fetch stage feeding `mCpu_ctrl`. The block issues one Avalon-MM burst read of `BURST_LENGTH` instruction words per fetch permit and stores the returned words in an instruction FIFO. It presents the FIFO head to the controller as `inst` / `inst_valid` / `empty` and pops on instruction completion. On a jump it flushes the FIFO and redirects the fetch PC.

## Interface

Parameters:
- `WORD_BITS`, 32: instruction and data word width.
- `ADDR_BITS`, 32: byte address width.
- `BURST_LENGTH`, 4: words per burst. Range 2..8.
- `DEPTH`, 8: FIFO entries. Power of two, ≥ 2×`BURST_LENGTH`.
- `RESET_PC`, 0: fetch and head PC after reset. Word-aligned.

Ports (reset is `rst`, synchronous, active-high; clock is `clk`):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `i_permit_fetch`  in  1  fetch permit from controller; a level held for several cycles.
- `o_fetch_complete`  out  1  one-cycle pulse: the requested burst is fully written to the FIFO.
- `o_inst`  out  `WORD_BITS`  FIFO head word.
- `o_inst_valid`  out  1  head valid (FIFO not empty).
- `o_empty`  out  1  FIFO empty.
- `o_inst_pc`  out  `ADDR_BITS`  byte address of the head word.
- `i_inst_complete`  in  1  pop the head; ignored when empty.
- `i_jump`  in  1  redirect and flush strobe.
- `i_jump_addr`  in  `ADDR_BITS`  redirect target (word-aligned).
- `o_avm_address`  out  `ADDR_BITS`  burst start byte address.
- `o_avm_read`  out  1  read request.
- `o_avm_burstcount`  out  4  constant `BURST_LENGTH` while `o_avm_read` is high; 0 otherwise.
- `i_avm_waitrequest`  in  1  slave stall.
- `i_avm_readdata`  in  `WORD_BITS`  beat data.
- `i_avm_readdatavalid`  in  1  beat valid.

## Operation

- **Request latch.** A rising edge of `i_permit_fetch` (previous-cycle sample is 0, current is 1) sets `r_req`. `r_req` clears on the transition IDLE→REQ. Further edges while `r_req` is set are absorbed.
- **FSM states.**
  - IDLE → REQ when `r_req` and FIFO free slots (`DEPTH`−count) ≥ `BURST_LENGTH`. Count includes beats already accepted this cycle.
  - REQ: `o_avm_read`=1, `o_avm_address`=`fetch_pc`, `o_avm_burstcount`=`BURST_LENGTH`. All three are held stable while `i_avm_waitrequest`=1. REQ → RECV on the first cycle with `i_avm_waitrequest`=0.
  - RECV: each `i_avm_readdatavalid` beat is pushed to the FIFO and the beat counter increments. After beat `BURST_LENGTH`−1, go to DONE and set `fetch_pc` ← `fetch_pc` + 4×`BURST_LENGTH` (wraps modulo 2^`ADDR_BITS`).
  - DONE: `o_fetch_complete`=1 for exactly this cycle, then → IDLE.
- **FIFO.** Circular buffer with a `log2(DEPTH)+1`-bit count. Pointers wrap at `DEPTH`. A push and a pop in the same cycle leave the count unchanged. Each pop advances `o_inst_pc` by 4. A push while full cannot occur because of the free-space check; the bench asserts on it.
- **Jump (`i_jump`=1).**
  - Next cycle: FIFO count=0, read and write pointers=0, `o_inst_pc` ← `i_jump_addr`, `fetch_pc` ← `i_jump_addr`.
  - Jump overrides any same-cycle push or pop.
  - Jump in IDLE or DONE: DONE still pulses `o_fetch_complete`.
  - Jump in REQ or RECV: the in-flight burst is marked stale. Its address and request hold as the Avalon protocol requires. Remaining beats are counted but not written to the FIFO. The burst end does not advance `fetch_pc` and does not pulse `o_fetch_complete`; the FSM goes straight to IDLE.
  - A pending `r_req` survives a jump and is then served from the new PC.
- **Reset mid-burst.** All state is cleared immediately. Beats from the abandoned burst arriving after reset are ignored, because the FSM is in IDLE with the counter at 0. The system must not issue a new burst to a slave with outstanding beats; the controller guarantees this because it holds `r_boot`=0 until the slave is idle.

## Timing

- **Reset values.**
  - `o_fetch_complete`=0, `o_inst_valid`=0, `o_empty`=1, `o_inst`=0.
  - `o_inst_pc`=`RESET_PC`.
  - `o_avm_read`=0, `o_avm_address`=0, `o_avm_burstcount`=0.
  - FSM in IDLE, `r_req`=0.
- **Request latency.** A permit edge at cycle N is sampled at N; `o_avm_read` rises at N+2 at the earliest.
- **Beat latency.** A beat accepted at cycle M is visible on `o_inst` / `o_inst_valid` at M+1. The first beat into an empty FIFO drives `o_empty` low at M+1.
- **Completion.** `o_fetch_complete` pulses at L+1, where L is the last-beat cycle; all burst words are readable by then.
- **Pop.** `i_inst_complete` at cycle P shows the next head word at P+1.
- **Registering.** All outputs are registered or driven from registered state. No combinational path from any input to any output.

## Test plan

- **Basic burst.** Reset, then `i_permit_fetch`=1 for 4 cycles, with `RESET_PC`=0 and slave returning 0x11,0x22,0x33,0x44 with no stalls → exactly one read at address 0 with burstcount 4; `o_fetch_complete` pulses once, one cycle after beat 4; `o_inst`=0x11, `o_inst_pc`=0; the next permit reads from address 0x10.
- **Slave stall and sparse beats.** `i_avm_waitrequest`=1 for 3 cycles, then beats spaced 2 cycles apart → address and request stay stable through the stall; the FIFO holds all 4 words in order; a single completion pulse.
- **Pops and simultaneous push/pop.** Pop 4 times; then pop while a beat arrives → `o_inst_pc` steps 0,4,8,C; count unchanged in the push/pop cycle; `o_empty`=1 after the last pop with nothing pending.
- **Jump with full FIFO.** FIFO full (8 entries), `i_jump` to 0x200 → next cycle `o_empty`=1 and `o_inst_pc`=0x200; the next permit reads from 0x200.
- **Jump during burst.** `i_jump` to 0x80 after beat 2 of a burst at 0x40 → beats 3–4 discarded; no `o_fetch_complete`; FIFO empty; the following burst address is 0x80.
- **Free-space gating and PC wrap.**
  - FIFO holds 6 of 8 entries and a permit arrives → no request until 2 pops have occurred.
  - `fetch_pc`=0xFFFFFFF0 → the next `fetch_pc` is 0x00000000.
